// File: rtl/neopixel_strand_decoder.sv
// Decodes a WS2812-style serial strand into 24-bit pixel commands, classifying
// each high pulse by width and closing the frame after a long low reset gap.
module neopixel_strand_decoder #(
    parameter int NUM_PIXELS   = 5,
    parameter int BIT_THRESH   = 27,
    parameter int MIN_HIGH     = 8,
    parameter int MAX_HIGH     = 60,
    parameter int RESET_CYCLES = 2500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        neo_data,
    output logic [23:0] pixel_data,
    output logic [2:0]  pixel_index,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        bit_error,
    output logic        busy
);

    localparam int PW = $clog2(NUM_PIXELS + 2);

    localparam logic [6:0]    MIN_H  = 7'(MIN_HIGH);
    localparam logic [6:0]    MAX_H  = 7'(MAX_HIGH);
    localparam logic [6:0]    H_SAT  = 7'(MAX_HIGH + 1);
    localparam logic [6:0]    THR    = 7'(BIT_THRESH);
    localparam logic [11:0]   L_SAT  = 12'(RESET_CYCLES);
    localparam logic [PW-1:0] NPIX   = PW'(NUM_PIXELS);
    localparam logic [PW-1:0] P_SAT  = PW'(NUM_PIXELS + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, ERROR} state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [6:0]    hcnt_q, hcnt_d;
    logic [11:0]   lcnt_q, lcnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [4:0]    bitpos_q, bitpos_d;
    logic [PW-1:0] pix_q, pix_d;
    logic          err_q, err_d;
    logic [23:0]   pdata_q, pdata_d;
    logic [2:0]    pidx_q, pidx_d;
    logic          pvalid_q, pvalid_d;
    logic          fdone_q, fdone_d;
    logic          fok_q, fok_d;
    logic          berr_q, berr_d;

    logic          line, rise;
    logic          take_bit, bit_val, clear_frame;
    logic [6:0]    hcnt_inc;
    logic [11:0]   lcnt_inc;

    assign line     = sync2_q;
    assign rise     = sync2_q & ~prev_q;
    assign hcnt_inc = (hcnt_q >= H_SAT) ? H_SAT : hcnt_q + 7'd1;
    assign lcnt_inc = (lcnt_q >= L_SAT) ? L_SAT : lcnt_q + 12'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            state_q  <= IDLE;
            hcnt_q   <= '0;
            lcnt_q   <= '0;
            shift_q  <= '0;
            bitpos_q <= '0;
            pix_q    <= '0;
            err_q    <= 1'b0;
            pdata_q  <= '0;
            pidx_q   <= '0;
            pvalid_q <= 1'b0;
            fdone_q  <= 1'b0;
            fok_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            sync1_q  <= neo_data;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            shift_q  <= shift_d;
            bitpos_q <= bitpos_d;
            pix_q    <= pix_d;
            err_q    <= err_d;
            pdata_q  <= pdata_d;
            pidx_q   <= pidx_d;
            pvalid_q <= pvalid_d;
            fdone_q  <= fdone_d;
            fok_q    <= fok_d;
            berr_q   <= berr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        lcnt_d      = lcnt_q;
        shift_d     = shift_q;
        bitpos_d    = bitpos_q;
        pix_d       = pix_q;
        err_d       = err_q;
        pdata_d     = pdata_q;
        pidx_d      = pidx_q;
        pvalid_d    = 1'b0;
        fdone_d     = 1'b0;
        fok_d       = 1'b0;
        berr_d      = 1'b0;
        take_bit    = 1'b0;
        bit_val     = 1'b0;
        clear_frame = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = 7'd1;
                end
            end
            HIGH: begin
                if (!line) begin
                    if (hcnt_q < MIN_H || hcnt_q > MAX_H) begin
                        state_d = ERROR;
                        berr_d  = 1'b1;
                        err_d   = 1'b1;
                        lcnt_d  = '0;
                    end else begin
                        take_bit = 1'b1;
                        bit_val  = (hcnt_q >= THR);
                        state_d  = LOW;
                        lcnt_d   = 12'd1;
                    end
                end else if (hcnt_q >= H_SAT) begin
                    // Stuck-high line: flag it now rather than waiting for a fall.
                    state_d = ERROR;
                    berr_d  = 1'b1;
                    err_d   = 1'b1;
                    lcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = 7'd1;
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc == L_SAT) begin
                        state_d     = IDLE;
                        fdone_d     = 1'b1;
                        fok_d       = !err_q && (pix_q == NPIX) && (bitpos_q == 5'd0);
                        clear_frame = 1'b1;
                    end
                end
            end
            ERROR: begin
                if (line) begin
                    lcnt_d = '0;
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc == L_SAT) begin
                        state_d     = IDLE;
                        fdone_d     = 1'b1;
                        clear_frame = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // First bit of a command ends up in bit 0 after 24 right-shifts.
        if (take_bit) begin
            shift_d = {bit_val, shift_q[23:1]};
            if (bitpos_q == 5'd23) begin
                bitpos_d = '0;
                if (pix_q < NPIX) begin
                    pvalid_d = 1'b1;
                    pdata_d  = shift_d;
                    pidx_d   = 3'(pix_q);
                end
                if (pix_q < P_SAT)
                    pix_d = pix_q + 1'b1;
            end else begin
                bitpos_d = bitpos_q + 5'd1;
            end
        end

        if (clear_frame) begin
            shift_d  = '0;
            bitpos_d = '0;
            pix_d    = '0;
            err_d    = 1'b0;
        end
    end

    assign pixel_data  = pdata_q;
    assign pixel_index = pidx_q;
    assign pixel_valid = pvalid_q;
    assign frame_done  = fdone_q;
    assign frame_ok    = fok_q;
    assign bit_error   = berr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_neopixel_strand_decoder.sv
// Directed bench for the NeoPixel strand decoder: one task per scenario.
module tb_neopixel_strand_decoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        neo_data = 1'b0;
    logic [23:0] pixel_data;
    logic [2:0]  pixel_index;
    logic        pixel_valid, frame_done, frame_ok, bit_error, busy;

    neopixel_strand_decoder dut (
        .clock(clock), .reset(reset), .neo_data(neo_data),
        .pixel_data(pixel_data), .pixel_index(pixel_index),
        .pixel_valid(pixel_valid), .frame_done(frame_done),
        .frame_ok(frame_ok), .bit_error(bit_error), .busy(busy)
    );

    always #10 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe recorder, sampled on the falling edge.
    logic [23:0] pv_data[$];
    logic [2:0]  pv_idx[$];
    int          fd_cnt  = 0;
    int          be_cnt  = 0;
    logic        last_ok = 1'b0;

    always @(negedge clock) begin
        if (pixel_valid) begin
            pv_data.push_back(pixel_data);
            pv_idx.push_back(pixel_index);
        end
        if (frame_done) begin
            fd_cnt  <= fd_cnt + 1;
            last_ok <= frame_ok;
        end
        if (bit_error) be_cnt <= be_cnt + 1;
    end

    // All stimulus tasks start and end 2 time units after a rising edge.
    task automatic pulse(input int hi, input int lo);
        neo_data = 1'b1;
        repeat (hi) @(posedge clock);
        #2 neo_data = 1'b0;
        repeat (lo) @(posedge clock);
        #2;
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(35, 30);
        else   pulse(18, 40);
    endtask

    task automatic send_pixel(input logic [23:0] v);
        for (int i = 0; i < 24; i++) send_bit(v[i]);
    endtask

    task automatic wait_fd(output bit got);
        int s;
        s = fd_cnt;
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #2;
            if (fd_cnt != s) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #5;
        n_checks++;
        if ({pixel_data, pixel_index, pixel_valid, frame_done, frame_ok, bit_error} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {pixel_data, pixel_index, pixel_valid, frame_done, frame_ok, bit_error});
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        @(posedge clock); #2 reset = 1'b0;
        repeat (2600) @(posedge clock);
        #2;
        n_checks++;
        if (fd_cnt !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_timeout: frame_done count %0d busy %b expected 0 0", fd_cnt, busy);
        end
    endtask

    task automatic test_basic_frame();
        int base, be0;
        bit got;
        base = pv_data.size();
        be0  = be_cnt;
        send_pixel(24'h000001);
        for (int k = 1; k < 5; k++) send_pixel(24'h000000);
        wait_fd(got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL basic_frame_done: timed out waiting for frame_done"); end
        n_checks++;
        if (pv_data.size() - base !== 5) begin
            n_fail++;
            $display("FAIL basic_pv_count: got %0d expected 5", pv_data.size() - base);
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (pv_idx[base+k] !== 3'(k)) begin
                    n_fail++;
                    $display("FAIL basic_index%0d: got %0d expected %0d", k, pv_idx[base+k], k);
                end
                n_checks++;
                if (pv_data[base+k] !== ((k == 0) ? 24'h000001 : 24'h000000)) begin
                    n_fail++;
                    $display("FAIL basic_data%0d: got %h expected %h", k, pv_data[base+k],
                             (k == 0) ? 24'h000001 : 24'h000000);
                end
            end
        end
        n_checks++;
        if (last_ok !== 1'b1) begin n_fail++; $display("FAIL basic_frame_ok: got %b expected 1", last_ok); end
        n_checks++;
        if (be_cnt != be0) begin n_fail++; $display("FAIL basic_bit_error: got %0d strobes expected 0", be_cnt - be0); end
        n_checks++;
        if (pixel_index !== 3'd4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_hold: index %0d busy %b expected 4 0", pixel_index, busy);
        end
    endtask

    task automatic test_threshold();
        int base, be0;
        bit got;
        base = pv_data.size();
        be0  = be_cnt;
        pulse(26, 40);   // just below threshold -> 0
        pulse(27, 40);   // at threshold -> 1
        pulse(8, 40);    // shortest legal -> 0
        pulse(60, 40);   // longest legal -> 1
        for (int i = 0; i < 20; i++) send_bit(1'b0);
        wait_fd(got);
        n_checks++;
        if (!got || last_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL thresh_frame: done %0d ok %b expected 1 0", got, last_ok);
        end
        n_checks++;
        if (pv_data.size() - base !== 1) begin
            n_fail++;
            $display("FAIL thresh_pv_count: got %0d expected 1", pv_data.size() - base);
        end else begin
            n_checks++;
            if (pv_data[base] !== 24'h00000A) begin
                n_fail++;
                $display("FAIL thresh_data: got %h expected 00000a", pv_data[base]);
            end
        end
        n_checks++;
        if (be_cnt != be0) begin n_fail++; $display("FAIL thresh_bit_error: got %0d strobes expected 0", be_cnt - be0); end
    endtask

    task automatic test_bit_error();
        int base, be0;
        bit got;
        base = pv_data.size();
        be0  = be_cnt;
        send_pixel(24'h123456);
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        pulse(5, 40);
        for (int i = 0; i < 30; i++) send_bit(1'b1);
        wait_fd(got);
        n_checks++;
        if (be_cnt - be0 !== 1) begin n_fail++; $display("FAIL short_bit_error: got %0d strobes expected 1", be_cnt - be0); end
        n_checks++;
        if (pv_data.size() - base !== 1) begin
            n_fail++;
            $display("FAIL short_pv_count: got %0d expected 1", pv_data.size() - base);
        end else begin
            n_checks++;
            if (pv_data[base] !== 24'h123456) begin
                n_fail++;
                $display("FAIL short_data: got %h expected 123456", pv_data[base]);
            end
        end
        n_checks++;
        if (!got || last_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL short_frame: done %0d ok %b expected 1 0", got, last_ok);
        end
    endtask

    task automatic test_long_pulse();
        int base, be0;
        bit got;
        base = pv_data.size();
        be0  = be_cnt;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        neo_data = 1'b1;
        repeat (70) @(posedge clock);
        #2;
        n_checks++;
        if (be_cnt - be0 !== 1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL long_bit_error: strobes %0d busy %b expected 1 1", be_cnt - be0, busy);
        end
        neo_data = 1'b0;
        wait_fd(got);
        n_checks++;
        if (!got || last_ok !== 1'b0 || pv_data.size() != base) begin
            n_fail++;
            $display("FAIL long_frame: done %0d ok %b pv %0d expected 1 0 0", got, last_ok, pv_data.size() - base);
        end
    endtask

    task automatic test_partial();
        int base;
        bit got;
        base = pv_data.size();
        send_pixel(24'h00ABCD);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        wait_fd(got);
        n_checks++;
        if (pv_data.size() - base !== 1) begin
            n_fail++;
            $display("FAIL partial_pv_count: got %0d expected 1", pv_data.size() - base);
        end else begin
            n_checks++;
            if (pv_data[base] !== 24'h00ABCD) begin
                n_fail++;
                $display("FAIL partial_data: got %h expected 00abcd", pv_data[base]);
            end
        end
        n_checks++;
        if (!got || last_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_frame: done %0d ok %b expected 1 0", got, last_ok);
        end
    endtask

    task automatic test_overflow();
        int base;
        bit got;
        base = pv_data.size();
        for (int k = 0; k < 6; k++) send_pixel(24'(k + 1));
        wait_fd(got);
        n_checks++;
        if (pv_data.size() - base !== 5) begin
            n_fail++;
            $display("FAIL over_pv_count: got %0d expected 5", pv_data.size() - base);
        end else begin
            n_checks++;
            if (pv_idx[base+4] !== 3'd4 || pv_data[base+4] !== 24'h000005) begin
                n_fail++;
                $display("FAIL over_last: index %0d data %h expected 4 000005", pv_idx[base+4], pv_data[base+4]);
            end
        end
        n_checks++;
        if (!got || last_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL over_frame: done %0d ok %b expected 1 0", got, last_ok);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base, fd0;
        bit got;
        base = pv_data.size();
        send_pixel(24'h0000AA);
        send_pixel(24'h0000BB);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        neo_data = 1'b1;
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || pixel_valid !== 1'b0 || pixel_data !== 24'd0 || pixel_index !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: busy %b valid %b data %h index %0d expected 0 0 0 0",
                     busy, pixel_valid, pixel_data, pixel_index);
        end
        neo_data = 1'b0;
        repeat (5) @(posedge clock);
        #2 reset = 1'b0;
        fd0 = fd_cnt;
        n_checks++;
        if (pv_data.size() - base !== 2) begin
            n_fail++;
            $display("FAIL mid_pre_count: got %0d expected 2", pv_data.size() - base);
        end
        base = pv_data.size();
        repeat (3000) @(posedge clock);
        #2;
        n_checks++;
        if (fd_cnt != fd0 || pv_data.size() != base) begin
            n_fail++;
            $display("FAIL mid_quiet: frame_done %0d pixel_valid %0d expected 0 0", fd_cnt - fd0, pv_data.size() - base);
        end
        for (int k = 0; k < 5; k++) send_pixel(24'(8'h10 + k));
        wait_fd(got);
        n_checks++;
        if (pv_data.size() - base !== 5) begin
            n_fail++;
            $display("FAIL mid_pv_count: got %0d expected 5", pv_data.size() - base);
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (pv_idx[base+k] !== 3'(k) || pv_data[base+k] !== 24'(8'h10 + k)) begin
                    n_fail++;
                    $display("FAIL mid_pixel%0d: index %0d data %h expected %0d %h",
                             k, pv_idx[base+k], pv_data[base+k], k, 24'(8'h10 + k));
                end
            end
        end
        n_checks++;
        if (!got || last_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_ok: done %0d ok %b expected 1 1", got, last_ok);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_threshold();
        test_bit_error();
        test_long_pulse();
        test_partial();
        test_overflow();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
